// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit adder slice with carry in/out, reused once per serial step.
module add4_slice
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
    assign o_sum  = w_full[NIBBLE_W-1:0];
    assign o_cout = w_full[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit slice per cycle, IDLE -> RUN -> DONE handshake.
// Optional subtract mode (A - B) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                         in_sub,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES:0]    out_sum
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                            r_state;
    logic                              r_in_ready;
    logic                              r_out_valid;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_res;
    logic                              r_cout;
    logic [IDX_W-1:0]                  r_idx;
    logic                              r_carry;

    logic [NIBBLE_W-1:0]               w_b_nib;
    logic [NIBBLE_W-1:0]               w_sum;
    logic                              w_cout;
    logic                              w_cin0;

`ifdef SERIAL_ADD_SUB_EN
    logic                              r_sub;

    // Subtraction is A + ~B + 1: invert every B nibble and seed the carry.
    assign w_b_nib = r_b[r_idx] ^ {NIBBLE_W{r_sub}};
    assign w_cin0  = in_sub;
`else
    assign w_b_nib = r_b[r_idx];
    assign w_cin0  = 1'b0;
`endif

    add4_slice u_slice (
        .i_a    (r_a[r_idx]),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cout      <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_res      <= '0;
                        r_cout     <= 1'b0;
                        r_idx      <= '0;
                        r_carry    <= w_cin0;
`ifdef SERIAL_ADD_SUB_EN
                        r_sub      <= in_sub;
`endif
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_res[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    r_idx        <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Release and accept never share an edge: IDLE is always visited.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = {r_cout, r_res};

endmodule
